// File: rtl/ac_match_reporter.sv
// rtl/ac_match_reporter.sv - Aho-Corasick match reporter: output table, hit counters, record FIFO
//
// Ports:
//   CLK, RST (async active-low)  clock and reset
//   INITIALIZE                   synchronous clear of stream state (table kept)
//   STEP_VALID, NOW_STATE,       per-character result from the table reader
//   EN_MATCH
//   TBL_WE, TBL_ADDR, TBL_DATA   output-table write port
//   REC_VALID, REC_READY,        match record stream (FIFO head)
//   REC_POS, REC_STATE, REC_MASK
//   HIT_CNT                      saturating per-pattern hit counters, packed
//   POS                          characters consumed
//   FIFO_LEVEL, OVERFLOW         record FIFO occupancy and sticky drop flag
module ac_match_reporter #(
    parameter int NUM_STATES = 32,
    parameter int NPAT       = 4,
    parameter int POS_W      = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    INITIALIZE,
    input  logic                    STEP_VALID,
    input  logic [7:0]              NOW_STATE,
    input  logic                    EN_MATCH,
    input  logic                    TBL_WE,
    input  logic [4:0]              TBL_ADDR,
    input  logic [NPAT-1:0]         TBL_DATA,
    output logic                    REC_VALID,
    input  logic                    REC_READY,
    output logic [POS_W-1:0]        REC_POS,
    output logic [7:0]              REC_STATE,
    output logic [NPAT-1:0]         REC_MASK,
    output logic [NPAT*CNT_W-1:0]   HIT_CNT,
    output logic [POS_W-1:0]        POS,
    output logic [LW-1:0]           FIFO_LEVEL,
    output logic                    OVERFLOW
);

    localparam logic [31:0] NS_U  = NUM_STATES;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    // Stream position and stage-1 register
    logic [POS_W-1:0] pos_q, pos_d;
    logic             s1_valid_q, s1_valid_d;
    logic [POS_W-1:0] s1_pos_q, s1_pos_d;
    logic [7:0]       s1_state_q, s1_state_d;
    logic             s1_en_q, s1_en_d;

    // Output table
    logic [NPAT-1:0]  tbl_q [NUM_STATES];
    logic [NPAT-1:0]  tbl_d [NUM_STATES];

    // Record FIFO
    logic [POS_W-1:0] mem_pos_q   [FIFO_DEPTH];
    logic [POS_W-1:0] mem_pos_d   [FIFO_DEPTH];
    logic [7:0]       mem_state_q [FIFO_DEPTH];
    logic [7:0]       mem_state_d [FIFO_DEPTH];
    logic [NPAT-1:0]  mem_mask_q  [FIFO_DEPTH];
    logic [NPAT-1:0]  mem_mask_d  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;

    // Hit counters
    logic [CNT_W-1:0] cnt_q [NPAT];
    logic [CNT_W-1:0] cnt_d [NPAT];

    logic [NPAT-1:0]  lut_mask;
    logic             match;
    logic             rec_valid;
    logic             full;
    logic             push;
    logic             push_ok;
    logic             pop;

    // Lookup uses the pre-edge table contents, so a write landing on the
    // same edge is not observed (read-before-write).
    always_comb begin
        lut_mask = '0;
        if ({24'd0, s1_state_q} < NS_U) begin
            lut_mask = tbl_q[s1_state_q[4:0]];
        end
    end

    assign match     = s1_valid_q && s1_en_q && (lut_mask != '0);
    assign rec_valid = (level_q != '0);
    assign full      = (level_q == FULL_LVL);
    assign pop       = rec_valid && REC_READY && !INITIALIZE;
    assign push      = match && !INITIALIZE;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);

    always_comb begin
        pos_d      = pos_q;
        s1_valid_d = 1'b0;
        s1_pos_d   = s1_pos_q;
        s1_state_d = s1_state_q;
        s1_en_d    = s1_en_q;
        if (STEP_VALID) begin
            s1_valid_d = 1'b1;
            s1_pos_d   = pos_q;
            s1_state_d = NOW_STATE;
            s1_en_d    = EN_MATCH;
            pos_d      = pos_q + POS_W'(1);
        end
        if (INITIALIZE) begin
            pos_d      = '0;
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (TBL_WE && ({27'd0, TBL_ADDR} < NS_U)) begin
            tbl_d[TBL_ADDR] = TBL_DATA;
        end
    end

    always_comb begin
        mem_pos_d   = mem_pos_q;
        mem_state_d = mem_state_q;
        mem_mask_d  = mem_mask_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        if (push_ok) begin
            mem_pos_d[wr_ptr_q]   = s1_pos_q;
            mem_state_d[wr_ptr_q] = s1_state_q;
            mem_mask_d[wr_ptr_q]  = lut_mask;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (INITIALIZE) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // Counters follow the lookup result, independent of whether the record fit.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NPAT; i++) begin
            if (INITIALIZE) begin
                cnt_d[i] = '0;
            end else if (match && lut_mask[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pos_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_pos_q    <= '0;
            s1_state_q  <= '0;
            s1_en_q     <= 1'b0;
            tbl_q       <= '{default: '0};
            mem_pos_q   <= '{default: '0};
            mem_state_q <= '{default: '0};
            mem_mask_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '{default: '0};
        end else begin
            pos_q       <= pos_d;
            s1_valid_q  <= s1_valid_d;
            s1_pos_q    <= s1_pos_d;
            s1_state_q  <= s1_state_d;
            s1_en_q     <= s1_en_d;
            tbl_q       <= tbl_d;
            mem_pos_q   <= mem_pos_d;
            mem_state_q <= mem_state_d;
            mem_mask_q  <= mem_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign REC_VALID  = rec_valid;
    assign REC_POS    = rec_valid ? mem_pos_q[rd_ptr_q]   : '0;
    assign REC_STATE  = rec_valid ? mem_state_q[rd_ptr_q] : '0;
    assign REC_MASK   = rec_valid ? mem_mask_q[rd_ptr_q]  : '0;
    assign POS        = pos_q;
    assign FIFO_LEVEL = level_q;
    assign OVERFLOW   = overflow_q;

    always_comb begin
        HIT_CNT = '0;
        for (int i = 0; i < NPAT; i++) begin
            HIT_CNT[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_ac_match_reporter.sv
// tb/tb_ac_match_reporter.sv - directed self-checking bench for ac_match_reporter
module tb_ac_match_reporter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INITIALIZE;
    logic        STEP_VALID;
    logic [7:0]  NOW_STATE;
    logic        EN_MATCH;
    logic        TBL_WE;
    logic [4:0]  TBL_ADDR;
    logic [3:0]  TBL_DATA;
    logic        REC_VALID;
    logic        REC_READY;
    logic [15:0] REC_POS;
    logic [7:0]  REC_STATE;
    logic [3:0]  REC_MASK;
    logic [63:0] HIT_CNT;
    logic [15:0] POS;
    logic [3:0]  FIFO_LEVEL;
    logic        OVERFLOW;

    int checks   = 0;
    int failures = 0;

    int         cap_pos[$];
    logic [7:0] cap_state[$];
    logic [3:0] cap_mask[$];

    always #5 CLK = ~CLK;

    ac_match_reporter dut (
        .CLK        (CLK),
        .RST        (RST),
        .INITIALIZE (INITIALIZE),
        .STEP_VALID (STEP_VALID),
        .NOW_STATE  (NOW_STATE),
        .EN_MATCH   (EN_MATCH),
        .TBL_WE     (TBL_WE),
        .TBL_ADDR   (TBL_ADDR),
        .TBL_DATA   (TBL_DATA),
        .REC_VALID  (REC_VALID),
        .REC_READY  (REC_READY),
        .REC_POS    (REC_POS),
        .REC_STATE  (REC_STATE),
        .REC_MASK   (REC_MASK),
        .HIT_CNT    (HIT_CNT),
        .POS        (POS),
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVERFLOW   (OVERFLOW)
    );

    // Record every handshake, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST && REC_VALID && REC_READY && !INITIALIZE) begin
            cap_pos.push_back(int'(REC_POS));
            cap_state.push_back(REC_STATE);
            cap_mask.push_back(REC_MASK);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic [7:0] st, input logic en);
        STEP_VALID = 1'b1;
        NOW_STATE  = st;
        EN_MATCH   = en;
        tick();
        STEP_VALID = 1'b0;
        NOW_STATE  = 8'd0;
        EN_MATCH   = 1'b0;
    endtask

    task automatic init_pulse();
        INITIALIZE = 1'b1;
        tick();
        INITIALIZE = 1'b0;
    endtask

    task automatic cap_clear();
        cap_pos.delete();
        cap_state.delete();
        cap_mask.delete();
    endtask

    initial begin
        RST        = 1'b0;
        INITIALIZE = 1'b0;
        STEP_VALID = 1'b0;
        NOW_STATE  = 8'd0;
        EN_MATCH   = 1'b0;
        TBL_WE     = 1'b0;
        TBL_ADDR   = 5'd0;
        TBL_DATA   = 4'd0;
        REC_READY  = 1'b0;
        #2;
        chk("rst_rec_valid", 64'(REC_VALID), 64'd0);
        chk("rst_pos", 64'(POS), 64'd0);
        chk("rst_level", 64'(FIFO_LEVEL), 64'd0);
        chk("rst_overflow", 64'(OVERFLOW), 64'd0);
        chk("rst_hit_cnt", HIT_CNT, 64'd0);
        tick();
        RST = 1'b1;
        tick();

        // Basic stream with two matches
        TBL_WE = 1'b1; TBL_ADDR = 5'd3; TBL_DATA = 4'b0001;
        tick();
        TBL_ADDR = 5'd7; TBL_DATA = 4'b0110;
        tick();
        TBL_WE = 1'b0;
        REC_READY = 1'b1;
        cap_clear();
        step(8'd1, 1'b0);
        step(8'd2, 1'b0);
        step(8'd3, 1'b1);
        step(8'd0, 1'b0);
        step(8'd7, 1'b1);
        tick(); tick(); tick();
        chk("t1_nrec", 64'(cap_pos.size()), 64'd2);
        chk("t1_rec0_pos", 64'(cap_pos[0]), 64'd2);
        chk("t1_rec0_state", 64'(cap_state[0]), 64'd3);
        chk("t1_rec0_mask", 64'(cap_mask[0]), 64'd1);
        chk("t1_rec1_pos", 64'(cap_pos[1]), 64'd4);
        chk("t1_rec1_state", 64'(cap_state[1]), 64'd7);
        chk("t1_rec1_mask", 64'(cap_mask[1]), 64'd6);
        chk("t1_hit_cnt", HIT_CNT, {16'd0, 16'd1, 16'd1, 16'd1});
        chk("t1_pos", 64'(POS), 64'd5);

        // Latency: step in cycle t, record visible in t+2, gone after pop
        REC_READY = 1'b0;
        step(8'd3, 1'b1);
        chk("t2_valid_t1", 64'(REC_VALID), 64'd0);
        chk("t2_pos_zero_when_invalid", 64'(REC_POS), 64'd0);
        tick();
        chk("t2_valid_t2", 64'(REC_VALID), 64'd1);
        chk("t2_rec_pos", 64'(REC_POS), 64'd5);
        REC_READY = 1'b1;
        tick();
        REC_READY = 1'b0;
        chk("t2_valid_after_pop", 64'(REC_VALID), 64'd0);
        chk("t2_mask_zero_when_invalid", 64'(REC_MASK), 64'd0);

        // Overflow: 9 matches into a depth-8 FIFO
        init_pulse();
        chk("t3_init_pos", 64'(POS), 64'd0);
        chk("t3_init_hit", HIT_CNT, 64'd0);
        for (int i = 0; i < 9; i++) step(8'd3, 1'b1);
        chk("t3_level_full", 64'(FIFO_LEVEL), 64'd8);
        chk("t3_no_ovf_yet", 64'(OVERFLOW), 64'd0);
        tick();
        chk("t3_level", 64'(FIFO_LEVEL), 64'd8);
        chk("t3_overflow", 64'(OVERFLOW), 64'd1);
        chk("t3_hit0", 64'(HIT_CNT[15:0]), 64'd9);
        cap_clear();
        REC_READY = 1'b1;
        repeat (8) tick();
        REC_READY = 1'b0;
        chk("t3_ndrained", 64'(cap_pos.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_order%0d", i), 64'(cap_pos[i]), 64'(i));
        chk("t3_overflow_sticky", 64'(OVERFLOW), 64'd1);
        chk("t3_level_empty", 64'(FIFO_LEVEL), 64'd0);

        // Full FIFO with simultaneous push and pop
        init_pulse();
        chk("t4_init_ovf", 64'(OVERFLOW), 64'd0);
        for (int i = 0; i < 9; i++) step(8'd3, 1'b1);
        REC_READY = 1'b1;
        tick();
        REC_READY = 1'b0;
        chk("t4_level", 64'(FIFO_LEVEL), 64'd8);
        chk("t4_overflow", 64'(OVERFLOW), 64'd0);
        cap_clear();
        REC_READY = 1'b1;
        repeat (8) tick();
        REC_READY = 1'b0;
        chk("t4_ndrained", 64'(cap_pos.size()), 64'd8);
        chk("t4_first", 64'(cap_pos[0]), 64'd1);
        chk("t4_last", 64'(cap_pos[7]), 64'd8);

        // Suppression and table timing
        init_pulse();
        step(8'd3, 1'b0);
        tick();
        chk("t5_noen_level", 64'(FIFO_LEVEL), 64'd0);
        chk("t5_noen_hit", HIT_CNT, 64'd0);
        step(8'd40, 1'b1);
        tick();
        chk("t5_oob_level", 64'(FIFO_LEVEL), 64'd0);
        chk("t5_oob_hit", HIT_CNT, 64'd0);
        step(8'd3, 1'b1);
        TBL_WE = 1'b1; TBL_ADDR = 5'd3; TBL_DATA = 4'b1000;
        tick();
        TBL_WE = 1'b0;
        chk("t5_rbw_valid", 64'(REC_VALID), 64'd1);
        chk("t5_rbw_mask", 64'(REC_MASK), 64'd1);
        chk("t5_rbw_pos", 64'(REC_POS), 64'd2);
        chk("t5_rbw_hit", HIT_CNT, {16'd0, 16'd0, 16'd0, 16'd1});
        step(8'd3, 1'b1);
        tick();
        chk("t5_level2", 64'(FIFO_LEVEL), 64'd2);
        REC_READY = 1'b1;
        tick();
        REC_READY = 1'b0;
        chk("t5_new_mask", 64'(REC_MASK), 64'd8);
        chk("t5_new_pos", 64'(REC_POS), 64'd3);
        chk("t5_new_hit", HIT_CNT, {16'd1, 16'd0, 16'd0, 16'd1});
        TBL_WE = 1'b1; TBL_ADDR = 5'd3; TBL_DATA = 4'b0001;
        tick();
        TBL_WE = 1'b0;

        // INITIALIZE overriding a step, table retained
        init_pulse();
        for (int i = 0; i < 3; i++) step(8'd3, 1'b1);
        tick();
        chk("t6_level3", 64'(FIFO_LEVEL), 64'd3);
        INITIALIZE = 1'b1; STEP_VALID = 1'b1; NOW_STATE = 8'd3; EN_MATCH = 1'b1;
        tick();
        INITIALIZE = 1'b0; STEP_VALID = 1'b0; NOW_STATE = 8'd0; EN_MATCH = 1'b0;
        chk("t6_pos", 64'(POS), 64'd0);
        chk("t6_level", 64'(FIFO_LEVEL), 64'd0);
        chk("t6_hit", HIT_CNT, 64'd0);
        chk("t6_overflow", 64'(OVERFLOW), 64'd0);
        tick();
        chk("t6_step_overridden", 64'(FIFO_LEVEL), 64'd0);
        step(8'd3, 1'b1);
        tick();
        chk("t6_tbl_kept_valid", 64'(REC_VALID), 64'd1);
        chk("t6_tbl_kept_mask", 64'(REC_MASK), 64'd1);
        chk("t6_tbl_kept_pos", 64'(REC_POS), 64'd0);

        // Asynchronous reset mid-stream
        step(8'd3, 1'b1);
        STEP_VALID = 1'b1; NOW_STATE = 8'd3; EN_MATCH = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        chk("t6_arst_valid", 64'(REC_VALID), 64'd0);
        chk("t6_arst_pos_rec", 64'(REC_POS), 64'd0);
        chk("t6_arst_state_rec", 64'(REC_STATE), 64'd0);
        chk("t6_arst_mask_rec", 64'(REC_MASK), 64'd0);
        chk("t6_arst_hit", HIT_CNT, 64'd0);
        chk("t6_arst_pos", 64'(POS), 64'd0);
        chk("t6_arst_level", 64'(FIFO_LEVEL), 64'd0);
        chk("t6_arst_ovf", 64'(OVERFLOW), 64'd0);
        STEP_VALID = 1'b0; NOW_STATE = 8'd0; EN_MATCH = 1'b0;
        tick();
        RST = 1'b1;
        step(8'd3, 1'b1);
        tick();
        chk("t6_tbl_cleared", 64'(FIFO_LEVEL), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
